// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream
//   N-to-1, WIDTH-bit stream multiplexer with a valid/ready handshake on every
//   input channel and a one-deep registered output stage. The selected word
//   crosses a register boundary without loss or duplication under backpressure.
//
//   Build option: define MUX_RR_ARB_EN to replace the external select with
//   round-robin arbitration among valid channels. Without the macro the
//   channel is chosen by sel and no round-robin pointer is built.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   sel        in   SEL_W    channel select (ignored in round-robin build)
//   in_valid   in   N        per-channel valid
//   in_ready   out  N        per-channel ready, combinational
//   in_data    in   N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//   out_valid  out  1        output register holds a word
//   out_ready  in   1        downstream accepts the word
//   out_data   out  WIDTH    registered data
//   out_sel    out  SEL_W    channel that produced out_data

module mux_nto1_stream #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel
);

    logic             load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     grant_oh;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    // Output register can accept a word when empty or when its word leaves now.
    assign load = !out_valid || out_ready;

`ifdef MUX_RR_ARB_EN
    logic [SEL_W-1:0] rr_ptr;
    logic             unused_sel;
    int               rr_idx;

    assign unused_sel = ^sel;

    // Search rr_ptr, rr_ptr+1, ... modulo N. Iterating from the far end lets
    // the closest valid channel overwrite any later candidate.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            rr_idx = (int'(rr_ptr) + k) % N;
            if (in_valid[rr_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= SEL_W'((int'(grant_idx) + 1) % N);
        end
    end
`else
    // An out-of-range select grants nobody.
    always_comb begin
        grant_valid = (int'(sel) < N);
        grant_idx   = sel;
    end
`endif

    // One-hot grant and data select; built as loops so an out-of-range index
    // never addresses a nonexistent channel.
    always_comb begin
        grant_oh   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_valid && (grant_idx == SEL_W'(i))) begin
                grant_oh[i] = 1'b1;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = (!rst && load) ? grant_oh : '0;
    assign xfer     = |(in_valid & in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_stream.sv
module tb_mux_nto1_stream;

    logic        clk = 1'b0;
    logic        rst;

    // N=4 instance
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;

    // N=3 instance
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [23:0] in_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_nto1_stream #(.N(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
    );

    mux_nto1_stream #(.N(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_sel(out_sel3)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 2'd0; in_valid = 4'b1111; in_data = 32'h44332211;
        out_ready = 1'b1;
        sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = '0; out_ready3 = 1'b1;
        step();
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_in_ready got=%b want=0000", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        rst = 1'b0;
        // load a word, then assert reset mid-cycle
        sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_sel !== 2'd1) begin bad++; $display("FAIL pre_rst_load got=%b/%h/%0d want=1/22/1", out_valid, out_data, out_sel); end
        #2;
        out_ready = 1'b1; in_valid = 4'b1111;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin bad++; $display("FAIL async_rst got=%b/%h/%0d want=0/00/0", out_valid, out_data, out_sel); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_held_in_ready got=%b want=0000", in_ready); end
        step();
        total++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin bad++; $display("FAIL rst_held_edge got=%b/%b want=0/0000", out_valid, in_ready); end
        rst = 1'b0;
        in_valid = 4'b0000;
        #1;
    endtask

`ifndef MUX_RR_ARB_EN
    task automatic test_select();
        sel = 2'd2; in_valid = 4'b1111; in_data = 32'h33A51100; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL sel2_in_ready got=%b want=0100", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin bad++; $display("FAIL sel2_out got=%b/%h/%0d want=1/a5/2", out_valid, out_data, out_sel); end
        sel = 2'd0; in_data = 32'h33A5117E;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL sel0_in_ready got=%b want=0001", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h7E || out_sel !== 2'd0) begin bad++; $display("FAIL sel0_out got=%b/%h/%0d want=1/7e/0", out_valid, out_data, out_sel); end
        // selected channel not valid: ready still shown, no transfer, word drains
        sel = 2'd3; in_valid = 4'b0111;
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL sel3_idle_ready got=%b want=1000", in_ready); end
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h7E || out_sel !== 2'd0) begin bad++; $display("FAIL drain_hold got=%b/%h/%0d want=0/7e/0", out_valid, out_data, out_sel); end
    endtask

    task automatic test_backpressure();
        sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00005A00; out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_load_ready got=%b want=0010", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sel !== 2'd1) begin bad++; $display("FAIL bp_load got=%b/%h/%0d want=1/5a/1", out_valid, out_data, out_sel); end
        in_valid = 4'b1111; in_data = 32'h7C006B00; sel = 2'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready c=%0d got=%b want=0000", c, in_ready); end
            step();
            total++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sel !== 2'd1) begin bad++; $display("FAIL bp_stall_hold c=%0d got=%b/%h/%0d want=1/5a/1", c, out_valid, out_data, out_sel); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b want=1000", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h7C || out_sel !== 2'd3) begin bad++; $display("FAIL bp_reload got=%b/%h/%0d want=1/7c/3", out_valid, out_data, out_sel); end
        in_valid = 4'b0000;
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h7C) begin bad++; $display("FAIL bp_drain got=%b/%h want=0/7c", out_valid, out_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        out_ready = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            in_data = {8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
            exp_d = 8'(8'h10 * (i + 1) + i);
            step();
            total++; if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== 2'(i)) begin bad++; $display("FAIL b2b i=%0d got=%b/%h/%0d want=1/%h/%0d", i, out_valid, out_data, out_sel, exp_d, i); end
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_out_of_range();
        sel3 = 2'd0; in_valid3 = 3'b001; in_data3 = 24'h000021; out_ready3 = 1'b0;
        step();
        total++; if (out_valid3 !== 1'b1 || out_data3 !== 8'h21) begin bad++; $display("FAIL oor_load got=%b/%h want=1/21", out_valid3, out_data3); end
        sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h998877;
        #1;
        total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL oor_stall_ready got=%b want=000", in_ready3); end
        step();
        out_ready3 = 1'b1;
        #1;
        total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL oor_ready got=%b want=000", in_ready3); end
        step();
        total++; if (out_valid3 !== 1'b0 || out_data3 !== 8'h21 || out_sel3 !== 2'd0) begin bad++; $display("FAIL oor_drain got=%b/%h/%0d want=0/21/0", out_valid3, out_data3, out_sel3); end
        step();
        total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL oor_no_xfer got=%b want=0", out_valid3); end
        in_valid3 = 3'b000;
    endtask
`else
    task automatic test_rr();
        logic [1:0] exp_a [5];
        logic [1:0] exp_b [4];
        exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_b = '{2'd1, 2'd3, 2'd1, 2'd3};
        pulse_reset();
        out_ready = 1'b1; in_valid = 4'b1111; in_data = 32'hC3C2C1C0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_sel !== exp_a[i] || out_data !== 8'(8'hC0 + exp_a[i])) begin bad++; $display("FAIL rr_all i=%0d got=%0d/%h want=%0d", i, out_sel, out_data, exp_a[i]); end
        end
        pulse_reset();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_sel !== exp_b[i]) begin bad++; $display("FAIL rr_1010 i=%0d got=%0d want=%0d", i, out_sel, exp_b[i]); end
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_rr_stall();
        pulse_reset();
        in_valid = 4'b0010; out_ready = 1'b0; in_data = 32'hD3D2D1D0;
        step();
        total++; if (out_valid !== 1'b1 || out_sel !== 2'd1) begin bad++; $display("FAIL rr_stall_load got=%b/%0d want=1/1", out_valid, out_sel); end
        in_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rr_stall_ready c=%0d got=%b want=0000", c, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL rr_resume_ready got=%b want=0100", in_ready); end
        step();
        total++; if (out_sel !== 2'd2 || out_data !== 8'hD2) begin bad++; $display("FAIL rr_resume got=%0d/%h want=2/d2", out_sel, out_data); end
        in_valid = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
`ifndef MUX_RR_ARB_EN
        test_select();
        test_backpressure();
        test_back_to_back();
        test_out_of_range();
`else
        test_rr();
        test_rr_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
